// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: bit-serial a - b - bin with a start/done handshake,
// one full-subtractor cell reused LSB first over WIDTH cycles.  Rev 1.0
`default_nettype none

module serial_subtractor_fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);
  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic [CW-1:0]    cnt;
  logic             brw;
  logic             cell_d;
  logic             cell_bo;

  serial_subtractor_fs u_cell (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .bin  (brw),
    .diff (cell_d),
    .bout (cell_bo)
  );

  assign res_nxt = {cell_d, res[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // abort takes priority over completion on the final RUN cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN: begin
        if (abort)             state_nxt = IDLE;
        else if (cnt == LAST)  state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a <= '0;
      sh_b <= '0;
      res  <= '0;
      cnt  <= '0;
      brw  <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
      zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh_a <= a;
            sh_b <= b;
            brw  <= bin;
            cnt  <= '0;
          end
        end
        RUN: begin
          if (!abort) begin
            sh_a <= sh_a >> 1;
            sh_b <= sh_b >> 1;
            res  <= res_nxt;
            brw  <= cell_bo;
            cnt  <= cnt + CW'(1);
            if (cnt == LAST) begin
              diff <= res_nxt;
              bout <= cell_bo;
              zero <= ~|res_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor_ctrl.sv
// tb_serial_subtractor_ctrl: randomized and directed checks of the serial
// subtractor against an arithmetic reference model (WIDTH=8).  Rev 1.0
`default_nettype none

module tb_serial_subtractor_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         ready, busy, done, bout, zero;
  logic [W-1:0] diff;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [W-1:0] last_diff = '0;
  logic         last_bout = 1'b0;
  logic         last_zero = 1'b0;

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .zero  (zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: unsigned arithmetic on widened operands
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                       output logic [W-1:0] md, output logic mbo, output logic mz);
    int unsigned va, vs;
    va  = ma;
    vs  = mb + mbin;
    md  = W'(va - vs);
    mbo = (va < vs);
    mz  = (md == '0);
  endtask

  // One operation; spam re-pulses start with fresh operands throughout RUN
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                        input bit spam);
    logic [W-1:0] ed;
    logic         ebo, ez;
    int           n;
    model(ta, tb, tbin, ed, ebo, ez);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      if (spam) start = 1'b1;
      if (n > 1 && !busy) check("busy_in_run", busy, 1);
      tick();
      n++;
    end
    start = 1'b0;
    check("latency", n, 9);
    check("diff", diff, ed);
    check("bout", bout, ebo);
    check("zero", zero, ez);
    check("ready_in_done", ready, 0);
    last_diff = ed; last_bout = ebo; last_zero = ez;
    tick();
    check("ready_after_done", {ready, done}, 2'b10);
  endtask

  initial begin
    int t0, t1;
    logic [W-1:0] ed;
    logic         ebo, ez;

    // 1: reset values before any clock edge
    #2;
    check("rst_outs", {ready, busy, done, diff, bout, zero}, {3'b100, 8'h00, 2'b00});
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", ready, 1);

    // 2-4: directed vectors
    run_op(8'h5A, 8'h3C, 1'b0, 0);
    run_op(8'h00, 8'h01, 1'b0, 0);
    run_op(8'h80, 8'h80, 1'b1, 0);
    run_op(8'h10, 8'h0F, 1'b1, 0);
    run_op(8'hFF, 8'h00, 1'b0, 0);

    // 5a: start spammed during RUN
    run_op(8'hC3, 8'h4D, 1'b1, 1);
    repeat (3) begin
      tick();
      check("no_extra_done", done, 0);
    end

    // 5b: start held high: one done per WIDTH+2 cycles
    a = 8'h37; b = 8'h92; bin = 1'b1;
    model(a, b, bin, ed, ebo, ez);
    start = 1'b1;
    t0 = 0;
    for (int k = 0; k < 4; k++) begin
      int g;
      g = 0;
      tick();
      while (!done && g < 15) begin tick(); g++; end
      check("held_done_seen", done, 1);
      check("held_diff", diff, ed);
      t1 = cyc;
      if (k > 0) check("held_period", t1 - t0, 10);
      t0 = t1;
    end
    start = 1'b0;
    last_diff = ed; last_bout = ebo; last_zero = ez;
    repeat (2) tick();

    // 6a: abort on RUN cycle 4
    a = 8'h01; b = 8'h02; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", {ready, busy}, 2'b10);
    for (int k = 0; k < 12; k++) begin
      if (done) check("abort_no_done", done, 0);
      tick();
    end
    check("abort_keep", {diff, bout, zero}, {last_diff, last_bout, last_zero});

    // 6b: async reset on RUN cycle 3, checked before the next edge
    a = 8'h22; b = 8'h11; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrun_rst", {ready, busy, done, diff, bout, zero}, {3'b100, 8'h00, 2'b00});
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op(8'h22, 8'h11, 1'b0, 0);

    // Randomized operations
    for (int k = 0; k < 20; k++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
